bin_frac_seq_mult_param: RTL

Parametrised shift-add sequential multiplier for binary fractions, one multiplier bit per clock, LSB first. It is the next generation of the fixed 7-bit fractional sequential multiplier. New features: configurable width, a per-operation signed (two's-complement Q1.(W-1)) or unsigned (0.W) mode, a busy/done handshake, and a rounded, saturated W-bit result with an overflow flag. It sits between operand registers and the datapath result bus.

---
 rtl/bin_frac_seq_mult_param_pkg.sv | 14 +
 rtl/seq_bit_counter.sv | 31 +++
 rtl/bin_frac_seq_mult_param.sv | 113 +++++++++++
 3 files changed

// File: rtl/bin_frac_seq_mult_param_pkg.sv
// Shared encodings for the parametrised shift-add fractional multiplier.
package bin_frac_seq_mult_param_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  typedef enum logic {
    ModeUns = 1'b0,
    ModeSgn = 1'b1
  } mode_e;

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable up-counter tracking the multiplier bit being processed.
module seq_bit_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/bin_frac_seq_mult_param.sv
// Shift-add fractional multiplier, one multiplier bit per clock, LSB first,
// with rounded/saturated W-bit result and busy/done handshake.
module bin_frac_seq_mult_param
  import bin_frac_seq_mult_param_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     product_rnd,
  output logic                 ovf
);

  state_e             state_q;
  mode_e              mode_q;
  logic [WIDTH:0]     acc_q, acc_nxt, addend, sum, rnd_wide;
  logic [WIDTH-1:0]   sr_q, sr_nxt, b_q, rnd_nxt;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               ovf_nxt, last, accept;

  assign accept = (state_q == StIdle) && start;

  seq_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .en       (state_q == StRun),
    .load     (1'b0),
    .load_val ('0),
    .tc       (last)
  );

  // The sign bit of a signed multiplier carries weight -1, hence the subtract.
  always_comb begin
    addend = '0;
    if (sr_q[0]) begin
      addend = (mode_q == ModeSgn) ? {b_q[WIDTH-1], b_q} : {1'b0, b_q};
    end
    if (last && (mode_q == ModeSgn)) begin
      sum = acc_q - addend;
    end else begin
      sum = acc_q + addend;
    end
    acc_nxt  = {(mode_q == ModeSgn) & sum[WIDTH], sum[WIDTH:1]};
    sr_nxt   = {sum[0], sr_q[WIDTH-1:1]};
    prod_nxt = {acc_nxt[WIDTH-1:0], sr_nxt};

    if (mode_q == ModeSgn) begin
      rnd_wide = {prod_nxt[2*WIDTH-1], prod_nxt[2*WIDTH-2:WIDTH-1]}
               + (WIDTH+1)'(prod_nxt[WIDTH-2]);
      ovf_nxt  = (rnd_wide[WIDTH:WIDTH-1] == 2'b01);
      rnd_nxt  = ovf_nxt ? {1'b0, {(WIDTH-1){1'b1}}} : rnd_wide[WIDTH-1:0];
    end else begin
      rnd_wide = {1'b0, prod_nxt[2*WIDTH-1:WIDTH]} + (WIDTH+1)'(prod_nxt[WIDTH-1]);
      ovf_nxt  = rnd_wide[WIDTH];
      rnd_nxt  = ovf_nxt ? {WIDTH{1'b1}} : rnd_wide[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= ModeUns;
      acc_q       <= '0;
      sr_q        <= '0;
      b_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      product     <= '0;
      product_rnd <= '0;
      ovf         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sr_q    <= a;
            b_q     <= b;
            mode_q  <= mode_e'(sgn);
            acc_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q <= acc_nxt;
          sr_q  <= sr_nxt;
          if (last) begin
            product     <= prod_nxt;
            product_rnd <= rnd_nxt;
            ovf         <= ovf_nxt;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
